// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
// Used by bin2bcd_serial and its dabble_digit per-digit adjuster.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int DABBLE_THRESH = 5;
    localparam int DABBLE_ADD    = 3;

endpackage

// File: rtl/bin2bcd_serial_dabble.sv
// One BCD digit of the double-dabble adjust step: add DABBLE_ADD when the digit
// is at or above DABBLE_THRESH, so the following left shift carries correctly.
module dabble_digit
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // Conditional add-3 ahead of the shift
    always_comb begin
        adjusted = digit;
        if (digit >= BCD_DIGIT_W'(DABBLE_THRESH)) begin
            adjusted = digit + BCD_DIGIT_W'(DABBLE_ADD);
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one operand bit per clock, with
// valid/ready handshakes on both sides. Optional macro BIN2BCD_SAT_EN saturates to all nines on overflow.
module bin2bcd_serial
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd,
    output logic                          overflow
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [BIN_W-1:0]   opnd_r;
    logic [BCD_W-1:0]   acc_r;
    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   acc_nxt_s;
    logic               ovf_acc_r;
    logic               ovf_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [BCD_W-1:0]   bcd_r;
    logic               ovf_r;
    logic               accept_s;
    logic               last_s;

`ifdef BIN2BCD_SAT_EN
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
`endif

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dabble
            dabble_digit u_dabble (
                .digit    (acc_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adjusted (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Handshake decode and next accumulator value for this iteration
    always_comb begin
        accept_s  = in_valid && (state_r == IDLE);
        last_s    = (state_r == SHIFT) && (cnt_r == CNT_W'(1));
        acc_nxt_s = {adj_s[BCD_W-2:0], opnd_r[BIN_W-1]};
        // the adjusted top bit is what falls off the top digit on this shift
        ovf_nxt_s = ovf_acc_r | adj_s[BCD_W-1];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = SHIFT;
                else          state_nxt_s = IDLE;
            end
            SHIFT: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = SHIFT;
            end
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Working datapath: operand shifter, accumulator, sticky overflow, iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_r    <= '0;
            acc_r     <= '0;
            ovf_acc_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opnd_r    <= bin;
                        acc_r     <= '0;
                        ovf_acc_r <= 1'b0;
                        cnt_r     <= CNT_W'(BIN_W);
                    end else begin
                        opnd_r    <= opnd_r;
                        acc_r     <= acc_r;
                        ovf_acc_r <= ovf_acc_r;
                        cnt_r     <= cnt_r;
                    end
                end
                SHIFT: begin
                    opnd_r    <= opnd_r << 1;
                    acc_r     <= acc_nxt_s;
                    ovf_acc_r <= ovf_nxt_s;
                    cnt_r     <= cnt_r - CNT_W'(1);
                end
                default: begin
                    opnd_r    <= opnd_r;
                    acc_r     <= acc_r;
                    ovf_acc_r <= ovf_acc_r;
                    cnt_r     <= cnt_r;
                end
            endcase
        end
    end

    // Result registers: captured on the final iteration, held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r <= '0;
            ovf_r <= 1'b0;
        end else if (last_s) begin
`ifdef BIN2BCD_SAT_EN
            bcd_r <= ovf_nxt_s ? ALL_NINES : acc_nxt_s;
`else
            bcd_r <= acc_nxt_s;
`endif
            ovf_r <= ovf_nxt_s;
        end else begin
            bcd_r <= bcd_r;
            ovf_r <= ovf_r;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign bcd       = bcd_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: a 16-bit/4-digit instance for the main
// scenarios plus a default-parameter instance for the 32-bit full-scale case.
module tb_bin2bcd_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd;
    logic        overflow;

    logic        d_in_valid;
    logic        d_in_ready;
    logic [31:0] d_bin;
    logic        d_out_valid;
    logic        d_out_ready;
    logic [39:0] d_bcd;
    logic        d_overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    bin2bcd_serial #(.BIN_W(16), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .overflow  (overflow)
    );

    bin2bcd_serial dut_def (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .bin       (d_bin),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .bcd       (d_bcd),
        .overflow  (d_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one operand and count cycles from the accept edge to out_valid
    task automatic convert(input logic [15:0] v, output int latency);
        @(negedge clk);
        bin      = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    // Complete the output handshake and confirm return to IDLE
    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        bin         = 16'd0;
        out_ready   = 1'b0;
        d_in_valid  = 1'b0;
        d_bin       = 32'd0;
        d_out_ready = 1'b0;

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_def_in_ready", 64'(d_in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        convert(16'd1234, lat);
        chk("r1234_latency", 64'(lat), 64'd16);
        chk("r1234_bcd", 64'(bcd), 64'h1234);
        chk("r1234_ovf", 64'(overflow), 64'd0);
        release_out("r1234");

        // bcd must hold the previous result while the next conversion runs
        @(negedge clk);
        bin      = 16'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("shift_out_valid", 64'(out_valid), 64'd0);
        chk("shift_bcd_hold", 64'(bcd), 64'h1234);
        chk("shift_in_ready", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("r0_latency", 64'(lat), 64'd13);
        chk("r0_bcd", 64'(bcd), 64'h0000);
        chk("r0_ovf", 64'(overflow), 64'd0);
        release_out("r0");

        convert(16'd9999, lat);
        chk("r9999_bcd", 64'(bcd), 64'h9999);
        chk("r9999_ovf", 64'(overflow), 64'd0);
        release_out("r9999");

        convert(16'd10000, lat);
        chk("r10000_ovf", 64'(overflow), 64'd1);
`ifdef BIN2BCD_SAT_EN
        chk("r10000_bcd", 64'(bcd), 64'h9999);
`else
        chk("r10000_bcd", 64'(bcd), 64'h0000);
`endif
        release_out("r10000");

        convert(16'd65535, lat);
        chk("r65535_ovf", 64'(overflow), 64'd1);
`ifdef BIN2BCD_SAT_EN
        chk("r65535_bcd", 64'(bcd), 64'h9999);
`else
        chk("r65535_bcd", 64'(bcd), 64'h5535);
`endif
        release_out("r65535");

        // Backpressure with stray in_valid pulses offering another operand
        convert(16'd4321, lat);
        chk("r4321_latency", 64'(lat), 64'd16);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bin      = 16'd77;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_bcd", 64'(bcd), 64'h4321);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        release_out("r4321");
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_restart", 64'(in_ready), 64'd1);

        // Reset in the seventh SHIFT cycle aborts the conversion
        @(negedge clk);
        bin      = 16'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_bcd", 64'(bcd), 64'd0);
        chk("abort_overflow", 64'(overflow), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(out_valid), 64'd0);

        convert(16'd42, lat);
        chk("r42_latency", 64'(lat), 64'd16);
        chk("r42_bcd", 64'(bcd), 64'h0042);
        chk("r42_ovf", 64'(overflow), 64'd0);
        release_out("r42");

        // Default parameters: 32-bit full scale into 10 digits
        @(negedge clk);
        d_bin      = 32'hFFFF_FFFF;
        d_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        lat = 0;
        while (!d_out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("def_latency", 64'(lat), 64'd32);
        chk("def_bcd", 64'(d_bcd), 64'h42_9496_7295);
        chk("def_ovf", 64'(d_overflow), 64'd0);
        @(negedge clk);
        d_out_ready = 1'b1;
        @(posedge clk);
        #1;
        d_out_ready = 1'b0;
        chk("def_in_ready_after", 64'(d_in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_serial.md
BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

Interface
REQ-001 Parameter BIN_W, default 32: binary input width in bits, legal range 1..64.
REQ-002 Parameter DIGITS, default 10: number of BCD output digits, legal range 1..20.
REQ-003 Port clk, input, 1 bit: single clock, rising-edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: the value on bin is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts a new operand.
REQ-007 Port bin, input, BIN_W bits: unsigned binary operand.
REQ-008 Port out_valid, output, 1 bit: bcd and overflow hold a valid result.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 Port bcd, output, DIGITS*4 bits: packed BCD result, with digit 0 (units) in bits [3:0].
REQ-011 Port overflow, output, 1 bit: the operand exceeded 10^DIGITS-1.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 in_ready SHALL equal (state==IDLE).
REQ-014 An operand is accepted on a clock edge where in_valid and in_ready are both high.
- On acceptance, the block SHALL latch bin, clear the BCD accumulator and the overflow flag, load the iteration counter with BIN_W, and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble iteration on the operand bits, MSB first.
- First, add 3 to every digit that is >= 5.
- Then shift the accumulator left by 1, inserting the current operand MSB.
REQ-016 A 1 shifted out of the top digit SHALL set the overflow flag; the flag is sticky for the whole conversion.
REQ-017 After exactly BIN_W SHIFT iterations, the FSM SHALL enter DONE.
- out_valid SHALL be high BIN_W cycles after the acceptance edge.
REQ-018 In DONE, out_valid SHALL remain high and bcd/overflow SHALL remain stable until out_ready is high on a clock edge; the FSM then returns to IDLE.
REQ-019 There SHALL be no bypass: in_valid is ignored outside IDLE, and in_ready rises one cycle after the output handshake.
REQ-020 out_valid SHALL be low in IDLE and SHIFT; bcd and overflow SHALL keep their last value outside DONE.
REQ-021 Without overflow, bcd SHALL equal the exact decimal value of bin.
- With overflow and saturation compiled out, bcd SHALL equal bin mod 10^DIGITS.
REQ-022 The overflow flag SHALL never be set when 10^DIGITS > 2^BIN_W-1.

Reset
REQ-023 While rst_n is low, the block SHALL hold: state IDLE, out_valid 0, bcd 0, overflow 0, counter 0.
- in_ready SHALL be 1 while rst_n is low.
REQ-024 Asserting rst_n mid-SHIFT or in DONE SHALL abort the conversion with no output handshake.

Configuration
REQ-025 Macro BIN2BCD_SAT_EN defined: on overflow, bcd SHALL present all digits = 9 and overflow = 1.
REQ-026 Macro BIN2BCD_SAT_EN undefined: bcd SHALL present the modulo result and overflow = 1; no saturation logic is synthesised.

Structure
REQ-027 Package bin2bcd_pkg SHALL hold the following, and the module SHALL contain no local copies of them:
- the FSM state enum (IDLE/SHIFT/DONE);
- constant BCD_DIGIT_W = 4;
- constant DABBLE_THRESH = 5;
- constant DABBLE_ADD = 3.
REQ-028 Sub-module dabble_digit SHALL be purely combinational (4-bit in, 4-bit adjusted out), instantiated DIGITS times via generate.

Verification (BIN_W=16, DIGITS=4 unless stated)
REQ-029 Latency: bin=1234, out_ready=1 -> out_valid high 16 cycles after the accept edge; bcd=0x1234, overflow=0; in_ready high the next cycle.
REQ-030 Boundary: bin=0 -> bcd=0x0000. bin=9999 -> bcd=0x9999, overflow=0.
REQ-031 Overflow: bin=10000 -> overflow=1.
- Without BIN2BCD_SAT_EN: bcd=0x0000.
- With BIN2BCD_SAT_EN: bcd=0x9999.
- bin=65535 without the macro -> bcd=0x5535, overflow=1.
REQ-032 Backpressure: out_ready held low 5 cycles in DONE -> out_valid and bcd=0x4321 stable throughout; in_valid pulses are ignored until the handshake.
REQ-033 Reset: rst_n low in SHIFT cycle 7 -> out_valid=0, bcd=0, in_ready=1 immediately.
- The next operand, 42, converts to 0x0042.
REQ-034 Default parameters: bin=32'hFFFF_FFFF -> bcd=40'h42_9496_7295, overflow=0, latency 32 cycles.
